mem_lsu: RTL
============

# mem_lsu

Load/store unit forming the MEM stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. It takes the EX/MEM-registered ALU result as the address, drives a req/gnt/rvalid data-memory port, generates byte enables and replicated store data, and returns sign/zero-extended load data to the MEM/WB boundary. While an access is outstanding it holds the pipeline via `stall_o`.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  MEM-stage instruction is valid.
- `mem_read_i`  in  1  instruction is a load.
- `mem_write_i`  in  1  instruction is a store. Never asserted together with `mem_read_i`.
- `funct3_i`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- `alu_result_i`  in  XLEN  effective byte address.
- `rs2_data_i`  in  XLEN  store data.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_be_o`  out  4  byte enables.
- `dmem_addr_o`  out  XLEN  word address: `{alu_result_i[31:2],2'b00}`.
- `dmem_wdata_o`  out  XLEN  lane-replicated store data.
- `dmem_gnt_i`  in  1  request accepted this cycle.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  XLEN  read data word.
- `load_data_o`  out  XLEN  formatted load result; 0 when `load_valid_o`=0.
- `load_valid_o`  out  1  one-cycle pulse when a load completes.
- `stall_o`  out  1  hold IF..MEM; bubble into WB.
- `misaligned_o`  out  1  misaligned access detected (see Configuration).

## Operation
- The stage performs an access when `valid_i & (mem_read_i | mem_write_i)`.
- FSM has three states: IDLE, REQ (waiting for grant) and WAIT (load waiting for rvalid). Reset state is IDLE.
- IDLE, access, `dmem_gnt_i`=1:
  - store -> IDLE (done).
  - load -> WAIT.
- IDLE, access, `dmem_gnt_i`=0 -> REQ.
- REQ, `dmem_gnt_i`=1:
  - store -> IDLE.
  - load -> WAIT.
- WAIT, `dmem_rvalid_i`=1 -> IDLE.
- `dmem_req_o` = (IDLE & access) | REQ. It is combinational, and address, we, be and wdata are driven from the inputs. The inputs stay stable because `stall_o` freezes EX/MEM.
- `stall_o` = `dmem_req_o & !(store & dmem_gnt_i)` | (WAIT & !`dmem_rvalid_i`).
- On grant of a load, register the byte offset `alu_result_i[1:0]` and `funct3_i`. Load formatting uses only these registered copies.
- Store enables and data:
  - SB: be = `4'b0001 << addr[1:0]`, wdata = `{4{rs2[7:0]}}`.
  - SH: be = `addr[1] ? 4'b1100 : 4'b0011`, wdata = `{2{rs2[15:0]}}`.
  - SW: be = 4'b1111, wdata = rs2.
- Loads drive be by the same rule and we = 0.
- Load formatting from `dmem_rdata_i`:
  - B/BU: select byte lane `off` and sign/zero-extend.
  - H/HU: select half `off[1]` and extend.
  - W: the full word.
- In IDLE and REQ, `dmem_rvalid_i` is ignored (stray responses are dropped).
- Reset asserted mid-access:
  - FSM goes to IDLE immediately.
  - `dmem_req_o` and `stall_o` drop asynchronously.
  - Registered offset and funct3 clear to 0.

## Timing
- Reset values:
  - `dmem_req_o`, `stall_o`, `load_valid_o`, `misaligned_o` = 0.
  - `load_data_o` = 0.
  - Other outputs are combinational from the inputs.
- Store with same-cycle grant: 0 stall cycles.
- Each cycle without grant adds 1 stall cycle.
- Load:
  - `dmem_rvalid_i` must arrive no earlier than the cycle after grant.
  - Minimum 1 stall cycle (the grant cycle).
  - `load_valid_o` and `load_data_o` are combinational in the rvalid cycle. In that same cycle `stall_o` = 0, so MEM/WB captures the data at the next edge.
- Only one access is outstanding at a time. No new request is issued while in WAIT.

## Configuration
- Macro `MEM_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned accesses are H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0.
  - They raise `misaligned_o` combinationally for that cycle.
  - They issue no request, keep `stall_o` = 0, and produce no `load_valid_o`.
- Undefined:
  - `misaligned_o` is tied to 0.
  - Low address bits not needed for the lane are ignored (H uses `addr[1]` only; W uses all lanes).

## Test plan
- SW, addr 0x1004, rs2 0xDEADBEEF, gnt same cycle -> req=1, we=1, be=1111, wdata 0xDEADBEEF, addr 0x1004, stall_o=0.
- SB, addr 0x1003, rs2 0x000000A5, gnt after 2 cycles -> be=1000, wdata 0xA5A5A5A5, stall_o=1 for 2 cycles then 0.
- LB, addr 0x2001, gnt same cycle, rvalid next cycle with rdata 0x12348056 -> stall_o=1 for one cycle, then load_valid_o=1 with load_data_o 0xFFFFFF80. The same case with LBU returns 0x00000080.
- LH, addr 0x2002, gnt delayed 1, rvalid delayed 3, rdata 0x8001_7FFF -> load_data_o 0xFFFF8001; stall_o high throughout until the rvalid cycle.
- Reset pulse in WAIT, then rvalid 0x11111111 in IDLE -> no load_valid_o, stall_o=0, no new req.
- LW at addr 0x3002:
  - With `MEM_MISALIGN_TRAP_EN`: misaligned_o=1, req=0, stall_o=0.
  - Without it: req=1, addr 0x3000, be=1111.

Source files
------------

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_if
// Description : Data-memory request/response bundle between the MEM-stage
//               load/store unit and the data memory.
//               master : req, we, be, addr, wdata out; gnt, rvalid, rdata in
//               slave  : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : MEM-stage load/store unit for a 5-stage RV32I pipeline.
//               Issues one req/gnt/rvalid data-memory access at a time,
//               builds byte enables and lane-replicated store data, formats
//               returned load data and stalls the pipeline while busy.
// Ports       : clk_i, rst_i (async, active-high)
//               valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i,
//               rs2_data_i                       - EX/MEM-registered inputs
//               dmem (mem_lsu_if.master)         - data-memory port
//               load_data_o, load_valid_o        - load result to MEM/WB
//               stall_o                          - hold IF..MEM
//               misaligned_o                     - misaligned access flag
// Options     : `define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses
//               and flag them on misaligned_o; otherwise misaligned_o = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int XLEN = 32
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            valid_i,
    input  wire logic            mem_read_i,
    input  wire logic            mem_write_i,
    input  wire logic [2:0]      funct3_i,
    input  wire logic [XLEN-1:0] alu_result_i,
    input  wire logic [XLEN-1:0] rs2_data_i,
    mem_lsu_if.master            dmem,
    output logic      [XLEN-1:0] load_data_o,
    output logic                 load_valid_o,
    output logic                 stall_o,
    output logic                 misaligned_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] off_q,   off_d;
    logic [2:0] f3_q,    f3_d;

    logic            w_access;
    logic            w_is_byte;
    logic            w_is_half;
    logic            w_misaligned;
    logic            w_issue;
    logic            w_req;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_lane_b;
    logic [15:0]     w_lane_h;
    logic [XLEN-1:0] w_fmt;

    assign w_access  = valid_i & (mem_read_i | mem_write_i);
    // 000/100 are byte, 001/101 are half; every other code is a word.
    assign w_is_byte = (funct3_i[1:0] == 2'b00);
    assign w_is_half = (funct3_i[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
    // Only a fresh access in IDLE can be misaligned; later states hold an
    // access that was already accepted as aligned.
    assign w_misaligned = w_access & (state_q == S_IDLE) &
                          ((w_is_half & alu_result_i[0]) |
                           (!w_is_byte && !w_is_half && (alu_result_i[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue = (state_q == S_IDLE) & w_access & !w_misaligned;
    // Reset gates the combinational request so it drops asynchronously.
    assign w_req   = !rst_i & (w_issue | (state_q == S_REQ));

    // Byte enables and replicated store data (loads reuse the enables).
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_i;
        if (w_is_byte) begin
            w_be    = 4'b0001 << alu_result_i[1:0];
            w_wdata = {4{rs2_data_i[7:0]}};
        end else if (w_is_half) begin
            w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{rs2_data_i[15:0]}};
        end
    end

    assign dmem.req   = w_req;
    assign dmem.we    = mem_write_i;
    assign dmem.be    = w_be;
    assign dmem.addr  = {alu_result_i[XLEN-1:2], 2'b00};
    assign dmem.wdata = w_wdata;

    // Next-state logic; offset/size are captured only when a load is granted
    // so formatting is immune to EX/MEM changes during WAIT.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        f3_d    = f3_q;
        case (state_q)
            S_IDLE: begin
                if (w_issue) begin
                    if (dmem.gnt) state_d = mem_write_i ? S_IDLE : S_WAIT;
                    else          state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem.gnt) state_d = mem_write_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (dmem.rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_req && dmem.gnt && !mem_write_i) begin
            off_d = alu_result_i[1:0];
            f3_d  = funct3_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
        end
    end

    // Load formatting from the registered offset/size.
    always_comb begin
        w_lane_b = dmem.rdata[{off_q, 3'b000} +: 8];
        w_lane_h = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (f3_q[1:0])
            2'b00:   w_fmt = {{(XLEN-8){!f3_q[2] & w_lane_b[7]}}, w_lane_b};
            2'b01:   w_fmt = {{(XLEN-16){!f3_q[2] & w_lane_h[15]}}, w_lane_h};
            default: w_fmt = dmem.rdata;
        endcase
    end

    assign load_valid_o = !rst_i & (state_q == S_WAIT) & dmem.rvalid;
    assign load_data_o  = load_valid_o ? w_fmt : '0;
    assign stall_o      = !rst_i & ((w_req & !(mem_write_i & dmem.gnt)) |
                                    ((state_q == S_WAIT) & !dmem.rvalid));
    assign misaligned_o = !rst_i & w_misaligned;

endmodule
`default_nettype wire
